pass_entry_tx: RTL and testbench



---
 rtl/pass_pkg.sv | 38 +++
 rtl/pass_timer.sv | 28 ++
 rtl/pass_entry_tx.sv | 178 +++++++++++++++++
 tb/tb_pass_entry_tx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pass_pkg.sv
// Shared types and constants for the keypad-side password transmitter.
package pass_pkg;

  // Transmitter FSM encoding.
  typedef enum logic [2:0] {
    StIdle     = 3'b000,
    StGot1     = 3'b001,
    StPresent  = 3'b010,
    StCooldown = 3'b011,
    StLockout  = 3'b100
  } state_e;

  // One keypad digit.
  typedef logic [1:0] digit_t;

  // Default timing and attempt limits.
  localparam int unsigned HoldCyclesDef     = 8;
  localparam int unsigned TimeoutCyclesDef  = 1000;
  localparam int unsigned CooldownCyclesDef = 4;
  localparam int unsigned MaxAttemptsDef    = 3;
  localparam int unsigned LockoutCyclesDef  = 2000;

  // Password the checker accepts.
  localparam digit_t RefDigit1 = 2'b01;
  localparam digit_t RefDigit2 = 2'b10;

  // Largest of four values, used to size the shared timer.
  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pass_timer.sv
// Clearable, saturating up-counter with a terminal-count compare against a per-state limit.
module pass_timer #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  // Count up while enabled; hold at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

  // Terminal count: the limit-th cycle spent in the current state.
  always_comb begin
    done = (count == (limit - WIDTH'(1)));
  end

endmodule

// File: rtl/pass_entry_tx.sv
// Collects two keypad digits, presents them to the checker for a fixed hold window,
// then cools down; counts failed attempts and locks the keypad out after too many.
module pass_entry_tx
  import pass_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES     = HoldCyclesDef,
  parameter int unsigned TIMEOUT_CYCLES  = TimeoutCyclesDef,
  parameter int unsigned COOLDOWN_CYCLES = CooldownCyclesDef,
  parameter int unsigned MAX_ATTEMPTS    = MaxAttemptsDef,
  parameter int unsigned LOCKOUT_CYCLES  = LockoutCyclesDef
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [1:0] key_code,
  input  logic       key_clear,
  input  logic       attempt_fail,
  output logic       sensor_entrance,
  output logic [1:0] password_1,
  output logic [1:0] password_2,
  output logic       entry_busy,
  output logic       locked,
  output logic [1:0] digit_count
);

  localparam int unsigned TimerMax =
      max4(HOLD_CYCLES, TIMEOUT_CYCLES, COOLDOWN_CYCLES, LOCKOUT_CYCLES);
  localparam int unsigned TimerWidth = $clog2(TimerMax) + 1;
  localparam int unsigned FailWidth  = $clog2(MAX_ATTEMPTS + 1);
  localparam logic [FailWidth-1:0] FailMax = FailWidth'(MAX_ATTEMPTS);

  state_e state_q, state_d;
  digit_t d1_q, d1_d;
  logic [FailWidth-1:0] fail_cnt_q, fail_cnt_nx, fail_cnt_d;
  logic fail_flag_q, fail_flag_nx, fail_flag_d;

  logic [TimerWidth-1:0] timer_limit;
  logic [TimerWidth-1:0] timer_count;
  logic                  timer_done;
  logic                  timer_clear;
  logic                  timer_en;

  logic       sensor_d;
  digit_t     pw1_d, pw2_d;
  logic       busy_d;
  logic       locked_d;
  logic [1:0] digit_cnt_d;

  // Per-state timer limit; IDLE holds the timer at zero so its limit is irrelevant.
  always_comb begin
    timer_limit = TimerWidth'(TIMEOUT_CYCLES);
    case (state_q)
      StGot1:     timer_limit = TimerWidth'(TIMEOUT_CYCLES);
      StPresent:  timer_limit = TimerWidth'(HOLD_CYCLES);
      StCooldown: timer_limit = TimerWidth'(COOLDOWN_CYCLES);
      StLockout:  timer_limit = TimerWidth'(LOCKOUT_CYCLES);
      default:    timer_limit = TimerWidth'(TIMEOUT_CYCLES);
    endcase
  end

  assign timer_clear = (state_d != state_q);
  assign timer_en    = (state_q != StIdle);

  pass_timer #(
    .WIDTH (TimerWidth)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .limit  (timer_limit),
    .count  (timer_count),
    .done   (timer_done)
  );

  // Fail accounting: one count per attempt, only while the attempt is in flight.
  always_comb begin
    fail_cnt_nx  = fail_cnt_q;
    fail_flag_nx = fail_flag_q;
    if (((state_q == StPresent) || (state_q == StCooldown)) && attempt_fail && !fail_flag_q) begin
      fail_flag_nx = 1'b1;
      if (fail_cnt_q < FailMax) fail_cnt_nx = fail_cnt_q + FailWidth'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (key_valid && !key_clear) state_d = StGot1;
      end
      StGot1: begin
        if (key_clear)       state_d = StIdle;
        else if (key_valid)  state_d = StPresent;
        else if (timer_done) state_d = StIdle;
      end
      StPresent: begin
        if (timer_done) state_d = StCooldown;
      end
      StCooldown: begin
        if (timer_done) state_d = (fail_cnt_nx == FailMax) ? StLockout : StIdle;
      end
      StLockout: begin
        if (timer_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Data-path next values: first digit, fail count and per-attempt flag.
  always_comb begin
    d1_d = d1_q;
    if ((state_q == StIdle) && (state_d == StGot1)) d1_d = key_code;
    else if (state_d == StIdle)                     d1_d = '0;

    fail_cnt_d = fail_cnt_nx;
    // A clean attempt breaks the run of failures; lockout expiry forgives them.
    if ((state_q == StCooldown) && timer_done && !fail_flag_nx) fail_cnt_d = '0;
    if ((state_q == StLockout) && timer_done)                   fail_cnt_d = '0;

    fail_flag_d = fail_flag_nx;
    if (!((state_q == StPresent) || (state_q == StCooldown)) ||
        !((state_d == StPresent) || (state_d == StCooldown))) begin
      fail_flag_d = 1'b0;
    end
  end

  // Output next values, derived from the state being entered so outputs are registered.
  always_comb begin
    sensor_d    = (state_d == StPresent);
    busy_d      = (state_d != StIdle);
    locked_d    = (state_d == StLockout);
    digit_cnt_d = 2'd0;
    pw1_d       = '0;
    pw2_d       = '0;
    case (state_d)
      StGot1:                digit_cnt_d = 2'd1;
      StPresent, StCooldown: digit_cnt_d = 2'd2;
      default:               digit_cnt_d = 2'd0;
    endcase
    if ((state_q == StGot1) && (state_d == StPresent)) begin
      pw1_d = d1_q;
      pw2_d = key_code;
    end else if ((state_d == StPresent) || (state_d == StCooldown)) begin
      pw1_d = password_1;
      pw2_d = password_2;
    end
  end

  // State, data-path and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      d1_q            <= '0;
      fail_cnt_q      <= '0;
      fail_flag_q     <= 1'b0;
      sensor_entrance <= 1'b0;
      password_1      <= '0;
      password_2      <= '0;
      entry_busy      <= 1'b0;
      locked          <= 1'b0;
      digit_count     <= 2'd0;
    end else begin
      state_q         <= state_d;
      d1_q            <= d1_d;
      fail_cnt_q      <= fail_cnt_d;
      fail_flag_q     <= fail_flag_d;
      sensor_entrance <= sensor_d;
      password_1      <= pw1_d;
      password_2      <= pw2_d;
      entry_busy      <= busy_d;
      locked          <= locked_d;
      digit_count     <= digit_cnt_d;
    end
  end

endmodule

// File: tb/tb_pass_entry_tx.sv
// Directed bench for pass_entry_tx: a scoreboard queue holds the digit pair each presentation
// must carry, and a monitor pops it when sensor_entrance rises.
module tb_pass_entry_tx;
  import pass_pkg::*;

  localparam int unsigned Hold = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [1:0] key_code = 2'b00;
  logic       key_clear = 1'b0;
  logic       attempt_fail = 1'b0;
  logic       sensor_entrance;
  logic [1:0] password_1;
  logic [1:0] password_2;
  logic       entry_busy;
  logic       locked;
  logic [1:0] digit_count;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] exp_q[$];
  logic [3:0] cur_exp = 4'h0;
  int         hi_len = 0;
  logic       prev_se = 1'b0;

  pass_entry_tx #(
    .HOLD_CYCLES     (Hold),
    .TIMEOUT_CYCLES  (1000),
    .COOLDOWN_CYCLES (4),
    .MAX_ATTEMPTS    (3),
    .LOCKOUT_CYCLES  (2000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .key_valid       (key_valid),
    .key_code        (key_code),
    .key_clear       (key_clear),
    .attempt_fail    (attempt_fail),
    .sensor_entrance (sensor_entrance),
    .password_1      (password_1),
    .password_2      (password_2),
    .entry_busy      (entry_busy),
    .locked          (locked),
    .digit_count     (digit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] code);
    key_valid = 1'b1;
    key_code  = code;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_se"}, {31'd0, sensor_entrance}, 32'd0);
    chk({tag, "_pw"}, {28'd0, password_1, password_2}, 32'd0);
    chk({tag, "_busy"}, {31'd0, entry_busy}, 32'd0);
    chk({tag, "_lock"}, {31'd0, locked}, 32'd0);
    chk({tag, "_dc"}, {30'd0, digit_count}, 32'd0);
  endtask

  // One full attempt: two digits, optional fail pulse in PRESENT plus a duplicate in COOLDOWN.
  task automatic attempt(input string tag, input logic [1:0] a, input logic [1:0] b,
                         input bit fail, input bit expect_lock);
    exp_q.push_back({a, b});
    press(a);
    press(b);                       // edge N: PRESENT
    attempt_fail = fail;
    tick();                         // N+1, still PRESENT
    attempt_fail = 1'b0;
    repeat (7) tick();              // N+8: COOLDOWN
    chk({tag, "_cool_se"}, {31'd0, sensor_entrance}, 32'd0);
    chk({tag, "_cool_pw"}, {28'd0, password_1, password_2}, {28'd0, a, b});
    attempt_fail = fail;
    tick();                         // N+9
    attempt_fail = 1'b0;
    repeat (3) tick();              // N+12: IDLE or LOCKOUT
    chk({tag, "_locked"}, {31'd0, locked}, {31'd0, expect_lock});
    chk({tag, "_busy"}, {31'd0, entry_busy}, {31'd0, expect_lock});
  endtask

  // Scoreboard monitor: pops the expected pair on each rising request, checks hold length.
  always @(negedge clk) begin
    if (reset) begin
      prev_se = 1'b0;
      hi_len  = 0;
    end else begin
      if (sensor_entrance) begin
        if (!prev_se) begin
          chk("sb_expected_present", exp_q.size() > 0, 32'd1);
          if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
          hi_len = 0;
        end
        hi_len++;
        chk("pw_stable", {28'd0, password_1, password_2}, {28'd0, cur_exp});
      end else if (prev_se) begin
        chk("hold_len", hi_len, Hold);
      end
      prev_se = sensor_entrance;
    end
  end

  initial begin
    // Reset state.
    tick();
    tick();
    chk_idle("reset");
    reset = 1'b0;
    tick();
    chk_idle("post_reset");

    // 1: reference password, keys two cycles apart.
    press(RefDigit1);
    chk("t1_dc1", {30'd0, digit_count}, 32'd1);
    chk("t1_busy1", {31'd0, entry_busy}, 32'd1);
    tick();
    exp_q.push_back({RefDigit1, RefDigit2});
    press(RefDigit2);               // edge N
    chk("t1_se", {31'd0, sensor_entrance}, 32'd1);
    chk("t1_dc2", {30'd0, digit_count}, 32'd2);
    repeat (11) tick();
    chk("t1_busy11", {31'd0, entry_busy}, 32'd1);
    tick();
    chk_idle("t1_end");

    // 2: single key then timeout.
    press(2'b11);                   // edge M
    repeat (999) tick();
    chk("t2_dc_before", {30'd0, digit_count}, 32'd1);
    tick();
    chk_idle("t2_timeout");
    exp_q.push_back({RefDigit1, RefDigit2});
    press(RefDigit1);
    press(RefDigit2);
    chk("t2_se", {31'd0, sensor_entrance}, 32'd1);
    repeat (12) tick();
    chk_idle("t2_end");

    // 3: clear wins over a simultaneous key, in GOT1 and in IDLE.
    press(RefDigit1);
    key_clear = 1'b1;
    press(RefDigit2);
    key_clear = 1'b0;
    chk_idle("t3_got1_clear");
    key_clear = 1'b1;
    press(RefDigit1);
    key_clear = 1'b0;
    chk_idle("t3_idle_clear");
    repeat (3) tick();
    chk("t3_no_se", {31'd0, sensor_entrance}, 32'd0);

    // 4: three failed attempts lock the keypad.
    attempt("t4_a1", 2'b00, 2'b00, 1'b1, 1'b0);
    attempt("t4_a2", 2'b00, 2'b00, 1'b1, 1'b0);
    attempt("t4_a3", 2'b00, 2'b00, 1'b1, 1'b1);   // edge L at end
    press(RefDigit1);                               // L+1, ignored
    chk("t4_lock_dc", {30'd0, digit_count}, 32'd0);
    repeat (1998) tick();                           // L+1999
    chk("t4_still_locked", {31'd0, locked}, 32'd1);
    tick();                                         // L+2000
    chk_idle("t4_unlock");

    // 5: lockout cleared the count; a clean attempt clears it again.
    attempt("t5_a1", 2'b00, 2'b00, 1'b1, 1'b0);
    attempt("t5_a2", 2'b00, 2'b00, 1'b1, 1'b0);
    attempt("t5_a3", RefDigit1, RefDigit2, 1'b0, 1'b0);
    attempt("t5_a4", 2'b00, 2'b00, 1'b1, 1'b0);
    attempt("t5_a5", 2'b00, 2'b00, 1'b1, 1'b0);

    // 6: reset during PRESENT cycle 3, with a key in the reset cycle.
    exp_q.push_back({RefDigit1, RefDigit2});
    press(RefDigit1);
    press(RefDigit2);               // edge N
    tick();
    tick();                         // N+2
    reset     = 1'b1;
    key_valid = 1'b1;
    key_code  = 2'b11;
    tick();                         // N+3: reset edge
    chk_idle("t6_reset");
    reset     = 1'b0;
    key_valid = 1'b0;
    tick();
    chk_idle("t6_after");

    chk("sb_drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
